// File: rtl/pipe_delay_line_if.sv
// Handshake bundle for pipe_delay_line: word/valid in, stall/flush controls,
// registered word/valid/occupancy out. Master drives inputs, slave is the delay line.
interface pipe_delay_line_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic [WIDTH-1:0] dataIn;
  logic             validIn;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] dataOut;
  logic             validOut;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output dataIn, validIn, stall, flush,
    input  dataOut, validOut, occupancy
  );

  modport slave (
    input  dataIn, validIn, stall, flush,
    output dataOut, validOut, occupancy
  );
endinterface

// File: rtl/pipe_delay_line.sv
// DEPTH-stage WIDTH-bit delay line with per-stage valid, stall, flush and occupancy.
// Define PIPE_DELAY_ZERO_BUBBLE_EN to force invalid stages to carry data 0.
module pipe_delay_line #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  pipe_delay_line_if.slave bus
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_delay_line: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_delay_line: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  // Flush wins over stall; the count moves by word-in minus word-out only on a shift.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (bus.flush) begin
      valid_d = '0;
      occ_d   = '0;
`ifdef PIPE_DELAY_ZERO_BUBBLE_EN
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '0;
      end
`endif
    end else if (!bus.stall) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      valid_d[0] = bus.validIn;
`ifdef PIPE_DELAY_ZERO_BUBBLE_EN
      data_d[0] = bus.validIn ? bus.dataIn : '0;
`else
      data_d[0] = bus.dataIn;
`endif
      case ({bus.validIn, valid_q[DEPTH-1]})
        2'b10:   occ_d = occ_q + CNT_W'(1);
        2'b01:   occ_d = occ_q - CNT_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.dataOut   = data_q[DEPTH-1];
  assign bus.validOut  = valid_q[DEPTH-1];
  assign bus.occupancy = occ_q;

endmodule
